out_pair_packer: RTL and testbench

Downstream consumer of the 5-input/2-output select stage: samples its complementary outputs `Out`/`Out_Bar` under a valid strobe and checks that they are true complements. Valid samples are packed LSB-first into a `WIDTH`-bit word, which is presented on a valid/ready output handshake. Invalid pairs (`Out == Out_Bar`) are dropped, flagged, and counted. It is the first clocked stage after the combinational select logic.

---
 rtl/out_pair_packer.sv | 118 +++++++++++
 tb/tb_out_pair_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_pair_packer.sv
// Samples the complementary Out/Out_Bar pair from the select stage, packs good
// samples LSB-first into a WIDTH-bit word, and flags/counts non-complementary pairs.
module out_pair_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Clear,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Out,
  input  logic             Out_Bar,
  output logic             Byte_Valid,
  input  logic             Byte_Ready,
  output logic [WIDTH-1:0] Byte_Data,
  output logic             Pair_Err,
  output logic [ERR_W-1:0] Err_Count,
  output logic             Dbg_State
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               pair_err_q, pair_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic accept;
  logic good_pair;
  logic transfer;
  logic last_bit;

  // Handshakes: a beat moves on a rising edge where valid && ready are both high.
  // In_Ready depends on state only; Byte_Data is frozen while Byte_Valid waits.
  assign accept    = In_Valid && (state_q == FILL);
  assign good_pair = Out ^ Out_Bar;
  assign transfer  = (state_q == HOLD) && Byte_Ready;
  assign last_bit  = (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (accept && good_pair && last_bit) state_d = HOLD;
        HOLD:    if (Byte_Ready) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // Output logic
  always_comb begin
    In_Ready   = (state_q == FILL);
    Byte_Valid = (state_q == HOLD);
    Dbg_State  = state_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    data_d     = data_q;
    pair_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (Clear) begin
      cnt_d     = '0;
      data_d    = '0;
      err_cnt_d = '0;
    end else if (accept && good_pair) begin
      data_d[cnt_q] = Out;
      cnt_d         = last_bit ? '0 : cnt_q + CNT_W'(1);
    end else if (accept) begin
      // Bad pair: data and bit position stay put so the word still needs WIDTH good bits.
      pair_err_d = 1'b1;
      if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
    end else if (transfer) begin
      data_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      data_q     <= '0;
      pair_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      pair_err_q <= pair_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign Byte_Data = data_q;
  assign Pair_Err  = pair_err_q;
  assign Err_Count = err_cnt_q;

endmodule

// File: tb/tb_out_pair_packer.sv
// Bench for out_pair_packer: directed scenarios plus random traffic against a
// bit-list reference model; a monitor pops expected words on each transfer.
module tb_out_pair_packer;

  localparam int WIDTH = 8;
  localparam int ERR_W = 8;

  // Clock / reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic Clear = 1'b0;
  logic In_Valid = 1'b0;
  logic Out = 1'b0;
  logic Out_Bar = 1'b1;
  logic Byte_Ready = 1'b0;

  always #5 CLK = ~CLK;

  logic             In_Ready, Byte_Valid, Pair_Err, Dbg_State;
  logic [WIDTH-1:0] Byte_Data;
  logic [ERR_W-1:0] Err_Count;

  logic             d2_In_Ready, d2_Byte_Valid, d2_Pair_Err, d2_Dbg_State;
  logic [WIDTH-1:0] d2_Byte_Data;
  logic [1:0]       d2_Err_Count;

  out_pair_packer #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .Clear(Clear), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Out(Out), .Out_Bar(Out_Bar), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Byte_Data(Byte_Data), .Pair_Err(Pair_Err), .Err_Count(Err_Count), .Dbg_State(Dbg_State)
  );

  out_pair_packer #(.WIDTH(WIDTH), .ERR_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .Clear(Clear), .In_Valid(In_Valid), .In_Ready(d2_In_Ready),
    .Out(Out), .Out_Bar(Out_Bar), .Byte_Valid(d2_Byte_Valid), .Byte_Ready(Byte_Ready),
    .Byte_Data(d2_Byte_Data), .Pair_Err(d2_Pair_Err), .Err_Count(d2_Err_Count),
    .Dbg_State(d2_Dbg_State)
  );

  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Reference model: a word is just the list of good bits collected so far.
  bit               m_hold;
  int               m_nbits;
  logic [WIDTH-1:0] m_word;
  int               m_errs;
  bit               m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hold  = 1'b0;
    m_nbits = 0;
    m_word  = '0;
    m_errs  = 0;
    m_perr  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit v, input bit o, input bit ob, input bit r,
                                     input bit c);
    m_perr = 1'b0;
    if (c) begin
      model_reset();
    end else if (!m_hold && v) begin
      if (o != ob) begin
        m_word = m_word | (WIDTH'(o) << m_nbits);
        m_nbits++;
        if (m_nbits == WIDTH) begin
          exp_q.push_back(m_word);
          m_hold  = 1'b1;
          m_word  = '0;
          m_nbits = 0;
        end
      end else begin
        m_errs++;
        m_perr = 1'b1;
      end
    end else if (m_hold && r) begin
      m_hold = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    chk("in_ready", In_Ready, !m_hold);
    chk("byte_valid", Byte_Valid, m_hold);
    chk("dbg_state", Dbg_State, m_hold);
    chk("pair_err", Pair_Err, m_perr);
    chk("err_count", Err_Count, (m_errs > 255) ? 255 : m_errs);
    chk("err_count_w2", d2_Err_Count, (m_errs > 3) ? 3 : m_errs);
    chk("pair_err_w2", d2_Pair_Err, m_perr);
    if (!m_hold) chk("fill_data", Byte_Data, m_word);
  endtask

  // Driver: one cycle of stimulus, outputs checked first against the model.
  task automatic cycle(input bit v, input bit o, input bit ob, input bit r, input bit c);
    @(negedge CLK);
    check_outputs();
    In_Valid   = v;
    Out        = o;
    Out_Bar    = ob;
    Byte_Ready = r;
    Clear      = c;
    model_step(v, o, ob, r, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: pops the expected word when the transfer beat is presented.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (RST_N && !Clear && Byte_Valid && Byte_Ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(Byte_Data), 32'hFFFF_FFFF);
        end else begin
          chk("word", Byte_Data, exp_q.pop_front());
        end
        words_seen++;
      end else if (RST_N && Byte_Valid && exp_q.size() != 0) begin
        chk("held_word", Byte_Data, exp_q[0]);
      end
    end
  end

  initial begin
    bit bits_4d [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int sat_seq [5] = '{1, 2, 3, 3, 3};
    int pulses;

    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_byte_valid", Byte_Valid, 0);
    chk("rst_byte_data", Byte_Data, 0);
    chk("rst_pair_err", Pair_Err, 0);
    chk("rst_err_count", Err_Count, 0);
    RST_N = 1'b1;

    // Pattern 1,0,1,1,0,0,1,0 -> 8'h4D, then held with In_Valid asserted
    for (int i = 0; i < 8; i++) cycle(1'b1, bits_4d[i], !bits_4d[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hold_4d", Byte_Data, 8'h4D);
      chk("hold_err", Err_Count, 0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("after_xfer_ready", In_Ready, 1);
    chk("after_xfer_data", Byte_Data, 0);

    // Bad pairs after the 3rd good sample do not consume a bit position
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("ff_word", Byte_Data, 8'hFF);
    chk("ff_valid", Byte_Valid, 1);
    chk("ff_errs", Err_Count, 2);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Saturation of the 2-bit counter
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'(i % 2), 1'(i % 2), 1'b0, 1'b0);
      if (i > 0) begin
        chk("sat_seq", d2_Err_Count, sat_seq[i-1]);
        pulses += int'(d2_Pair_Err);
      end
    end
    idle(1);
    chk("sat_seq", d2_Err_Count, sat_seq[4]);
    pulses += int'(d2_Pair_Err);
    chk("sat_pulses", pulses, 5);
    chk("sat_err8", Err_Count, 5);

    // Clear overrides a simultaneous good accept
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("clr_data", Byte_Data, 0);
    chk("clr_errs", Err_Count, 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("clr_ff_word", Byte_Data, 8'hFF);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit v, o, ob, r;
      v  = ($urandom_range(0, 9) < 7);
      o  = 1'($urandom_range(0, 1));
      ob = ($urandom_range(0, 99) < 15) ? o : !o;
      r  = 1'($urandom_range(0, 1));
      cycle(v, o, ob, r, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of HOLD discards the word
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("pre_rst_valid", Byte_Valid, 1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_byte_valid", Byte_Valid, 0);
    chk("arst_in_ready", In_Ready, 1);
    chk("arst_byte_data", Byte_Data, 0);
    chk("arst_err_count", Err_Count, 0);
    chk("arst_pair_err", Pair_Err, 0);
    model_reset();
    In_Valid = 1'b0;
    Byte_Ready = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    chk("words_seen_nonzero", (words_seen > 3), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
